// File: rtl/acc_threshold_monitor_pkg.sv
// Shared constants, FSM encoding and magnitude helper for the acceleration
// threshold monitor and its moving-average front end.
`timescale 1ns/1ps
package acc_threshold_monitor_pkg;

  localparam int unsigned       DATA_W         = 16;
  localparam int unsigned       DEF_DEPTH_LOG2 = 3;
  localparam logic signed [15:0] DEF_THRESH_HI = 16'sd10000;
  localparam logic signed [15:0] DEF_THRESH_LO = 16'sd8000;
  localparam int unsigned       DEF_HOLD_CNT   = 4;

  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ALARM  = 2'd2
  } mon_state_e;

  // |v| saturated: the single unrepresentable case -32768 maps to 32767.
  function automatic logic signed [15:0] sat_abs(input logic signed [15:0] v);
    if (v == 16'sh8000) return 16'sh7fff;
    return v[15] ? -v : v;
  endfunction

endpackage

// File: rtl/acc_threshold_monitor_moving_avg.sv
// moving_avg_filter: 2^DEPTH_LOG2-tap boxcar average of a signed 16-bit
// stream, one sample per clock, result registered with a one-cycle strobe.
`timescale 1ns/1ps
module moving_avg_filter
  import acc_threshold_monitor_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] acc_data,
  output logic                     filt_valid,
  output logic signed [DATA_W-1:0] filt_data
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int SUM_W = DATA_W + DEPTH_LOG2;

  logic signed [DATA_W-1:0]  buf_q [DEPTH];
  logic signed [SUM_W-1:0]   sum_q, sum_d;
  logic [DEPTH_LOG2-1:0]     wp_q;
  logic                      filt_valid_q;
  logic signed [DATA_W-1:0]  filt_data_q;
  logic signed [DATA_W-1:0]  avg_d;

  // Sum of DEPTH 16-bit values needs exactly DEPTH_LOG2 extra bits, so the
  // running update is exact; dropping the low bits is a floor division.
  always_comb begin
    sum_d = sum_q
          + $signed({{DEPTH_LOG2{acc_data[DATA_W-1]}}, acc_data})
          - $signed({{DEPTH_LOG2{buf_q[wp_q][DATA_W-1]}}, buf_q[wp_q]});
    avg_d = $signed(sum_d[SUM_W-1:DEPTH_LOG2]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the window must start at zero or the running sum would subtract
      // stale samples, so the buffer is reset like any other state.
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      sum_q        <= '0;
      wp_q         <= '0;
      filt_valid_q <= 1'b0;
      filt_data_q  <= '0;
    end else begin
      filt_valid_q <= sample_valid;
      if (sample_valid) begin
        buf_q[wp_q] <= acc_data;
        sum_q       <= sum_d;
        wp_q        <= wp_q + 1'b1;
        filt_data_q <= avg_d;
      end
    end
  end

  assign filt_valid = filt_valid_q;
  assign filt_data  = filt_data_q;

endmodule

// File: rtl/acc_threshold_monitor.sv
// Filtered X-axis acceleration monitor: moving average, hysteretic magnitude
// threshold with consecutive-sample debounce, alarm drives the board LED.
`timescale 1ns/1ps
module acc_threshold_monitor
  import acc_threshold_monitor_pkg::*;
#(
  parameter int unsigned        DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter logic signed [15:0] THRESH_HI  = DEF_THRESH_HI,
  parameter logic signed [15:0] THRESH_LO  = DEF_THRESH_LO,
  parameter int unsigned        HOLD_CNT   = DEF_HOLD_CNT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] acc_data,
  output logic                     filt_valid,
  output logic signed [DATA_W-1:0] filt_data,
  output logic                     alarm,
  output logic                     LED
);

  localparam int FILL_W = DEPTH_LOG2 + 1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'((2 ** DEPTH_LOG2) - 1);
  localparam logic [3:0]        HOLD_LAST = 4'(HOLD_CNT - 1);

  mon_state_e                state_q, state_d;
  logic [FILL_W-1:0]         fill_q, fill_d;
  logic [3:0]                dcnt_q, dcnt_d;
  logic                      alarm_q, alarm_d;
  logic signed [DATA_W-1:0]  mag;

  moving_avg_filter #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_filter (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .acc_data     (acc_data),
    .filt_valid   (filt_valid),
    .filt_data    (filt_data)
  );

  assign mag = sat_abs(filt_data);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path
    // through the case leaves one unassigned (which would infer a latch).
    state_d = state_q;
    fill_d  = fill_q;
    dcnt_d  = dcnt_q;
    alarm_d = alarm_q;
    if (filt_valid) begin
      unique case (state_q)
        ST_WARMUP: begin
          fill_d = fill_q + 1'b1;
          if (fill_q == FILL_LAST) state_d = ST_IDLE;
        end
        ST_IDLE: begin
          if (mag > THRESH_HI) begin
            if (dcnt_q == HOLD_LAST) begin
              state_d = ST_ALARM;
              alarm_d = 1'b1;
              dcnt_d  = '0;
            end else begin
              dcnt_d = dcnt_q + 1'b1;
            end
          end else begin
            dcnt_d = '0;
          end
        end
        ST_ALARM: begin
          if (mag < THRESH_LO) begin
            if (dcnt_q == HOLD_LAST) begin
              state_d = ST_IDLE;
              alarm_d = 1'b0;
              dcnt_d  = '0;
            end else begin
              dcnt_d = dcnt_q + 1'b1;
            end
          end else begin
            dcnt_d = '0;
          end
        end
        default: begin
          state_d = ST_WARMUP;
          fill_d  = '0;
          dcnt_d  = '0;
          alarm_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_WARMUP;
      fill_q  <= '0;
      dcnt_q  <= '0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      dcnt_q  <= dcnt_d;
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;
  assign LED   = alarm_q;

endmodule

// File: tb/tb_acc_threshold_monitor.sv
// Scoreboard bench for acc_threshold_monitor: directed vectors plus a
// back-to-back stream with a mid-stream reset.
`timescale 1ns/1ps
module tb_acc_threshold_monitor;
  import acc_threshold_monitor_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sample_valid = 1'b0;
  logic signed [15:0] acc_data = '0;
  logic               filt_valid;
  logic signed [15:0] filt_data;
  logic               alarm;
  logic               LED;

  always #5 clk = ~clk;

  acc_threshold_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .acc_data     (acc_data),
    .filt_valid   (filt_valid),
    .filt_data    (filt_data),
    .alarm        (alarm),
    .LED          (LED)
  );

  typedef struct packed {
    logic signed [15:0] filt;
    logic               alarm;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: window kept as plain array, sum recomputed from scratch.
  int         win[8];
  int         m_wp, m_fill, m_dcnt;
  logic       m_alarm;
  mon_state_e m_state;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    foreach (win[i]) win[i] = 0;
    m_wp = 0; m_fill = 0; m_dcnt = 0; m_alarm = 1'b0; m_state = ST_WARMUP;
  endtask

  task automatic model_accept(input logic signed [15:0] d);
    int   s, avg, mag;
    exp_t e;
    win[m_wp] = d;
    m_wp = (m_wp + 1) % 8;
    s = 0;
    foreach (win[i]) s += win[i];
    avg = s >>> 3;
    mag = (avg < 0) ? -avg : avg;
    if (mag > 32767) mag = 32767;
    case (m_state)
      ST_WARMUP: begin
        m_fill++;
        if (m_fill == 8) m_state = ST_IDLE;
      end
      ST_IDLE: begin
        if (mag > 10000) begin
          m_dcnt++;
          if (m_dcnt == 4) begin m_state = ST_ALARM; m_alarm = 1'b1; m_dcnt = 0; end
        end else m_dcnt = 0;
      end
      default: begin
        if (mag < 8000) begin
          m_dcnt++;
          if (m_dcnt == 4) begin m_state = ST_IDLE; m_alarm = 1'b0; m_dcnt = 0; end
        end else m_dcnt = 0;
      end
    endcase
    e.filt  = 16'(avg);
    e.alarm = m_alarm;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int d);
    acc_data     = 16'(d);
    sample_valid = 1'b1;
    model_accept(16'(d));
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
  endtask

  task automatic send_gap(input int d);
    send(d);
    idle(1);
  endtask

  task automatic do_reset();
    check("sb_drained", sb_q.size(), 0);
    rst = 1'b1;
    sample_valid = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_filt_valid", filt_valid, 0);
    check("rst_filt_data", filt_data, 0);
    check("rst_alarm", alarm, 0);
    check("rst_led", LED, 0);
  endtask

  // Monitor: pop on each filt_valid, then check alarm/LED one cycle later.
  logic pend = 1'b0;
  logic exp_al;
  exp_t mon_e;
  always @(negedge clk) begin
    if (pend) begin
      check("alarm", alarm, exp_al);
      check("led", LED, exp_al);
      pend = 1'b0;
    end
    if (filt_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_filt_valid: got filt_valid=1 expected no output at %0t", $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("filt_data", filt_data, mon_e.filt);
        exp_al = mon_e.alarm;
        pend   = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int r;
  initial begin
    model_reset();

    // Reset and warmup: 7 x 20000 -> 17500, alarm held low.
    do_reset();
    for (int k = 0; k < 7; k++) send_gap(20000);
    check("warm7_filt", filt_data, 17500);
    check("warm7_alarm", alarm, 0);

    // Debounced assert: warm up at 0, then constant 12000.
    do_reset();
    for (int k = 0; k < 8; k++) send_gap(0);
    for (int k = 0; k < 9; k++) send_gap(12000);
    check("assert_3rd_high", alarm, 0);
    send(12000);
    check("assert_t1", alarm, 0);
    idle(1);
    check("assert_t2", alarm, 1);

    // Hysteresis: 9000 sits in the band, then 0 releases after 4 samples.
    for (int k = 0; k < 20; k++) send_gap(9000);
    check("band_hold", alarm, 1);
    for (int k = 0; k < 3; k++) send_gap(0);
    check("release_3rd_low", alarm, 1);
    send_gap(0);
    check("release_4th_low", alarm, 0);

    // Negative full scale and saturated magnitude.
    do_reset();
    for (int k = 0; k < 8; k++) send_gap(-32768);
    check("neg_full_filt", filt_data, -32768);
    for (int k = 0; k < 3; k++) send_gap(-32768);
    check("neg_3rd_high", alarm, 0);
    send_gap(-32768);
    check("neg_sat_alarm", alarm, 1);

    // Floor rounding: window {-1, 0 x 7} averages to -1.
    do_reset();
    send_gap(-1);
    for (int k = 0; k < 7; k++) send_gap(0);
    check("floor_filt", filt_data, -1);

    // Interrupted debounce: 3 high, one at 9500, 3 high, then the 4th.
    do_reset();
    for (int k = 0; k < 8; k++) send_gap(12000);
    for (int k = 0; k < 3; k++) send_gap(12000);
    send_gap(-8000);
    check("interrupt_filt", filt_data, 9500);
    send_gap(20000);
    send_gap(12000);
    send_gap(12000);
    check("interrupt_no_alarm", alarm, 0);
    send_gap(12000);
    check("interrupt_4th_high", alarm, 1);

    // Back-to-back stream with a reset colliding with a strobe at cycle 50.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      r = int'($urandom_range(10000)) - 5000;
      acc_data     = 16'(r);
      sample_valid = 1'b1;
      if (i == 50) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
        model_accept(16'(r));
      end
      @(posedge clk);
      #1;
      if (i == 50) begin
        check("midrst_filt_valid", filt_valid, 0);
        check("midrst_filt_data", filt_data, 0);
        check("midrst_alarm", alarm, 0);
        check("midrst_led", LED, 0);
      end
    end
    rst = 1'b0;
    sample_valid = 1'b0;
    idle(3);

    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
